// File: rtl/score_display_pkg.sv
// Shared definitions for the seven-segment scoreboard controller:
// glyph table, converter state encoding and a decimal power helper.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int pow10(input int n);
    int r;
    r = 32'sd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'sd10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Iterative double-dabble engine: one add-3/shift step per clock.
// done is high during the final step, so bcd is valid the following cycle.
module bin2bcd_seq #(
  parameter int SCORE_W    = 14,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int SW = SCORE_W + BW;
  localparam int CW = $clog2(SCORE_W + 1);

  logic [SW-1:0] sh_r;
  logic [CW-1:0] cnt_r;
  logic          run_r;

  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
    logic [SW-1:0] t;
    t = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (t[SCORE_W+4*i +: 4] >= 4'd5) begin
        t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4] + 4'd3;
      end else begin
        t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4];
      end
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  // Load on start, then run exactly SCORE_W add-3/shift steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r  <= {SW{1'b0}};
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b0;
    end else if (start) begin
      sh_r  <= {{BW{1'b0}}, bin};
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b1;
    end else if (run_r) begin
      sh_r  <= dd_step(sh_r);
      cnt_r <= cnt_r + 1'b1;
      run_r <= (cnt_r != CW'(SCORE_W - 1));
    end else begin
      sh_r  <= sh_r;
      cnt_r <= cnt_r;
      run_r <= 1'b0;
    end
  end

  assign busy = run_r;
  assign done = run_r && (cnt_r == CW'(SCORE_W - 1));
  assign bcd  = sh_r[SCORE_W +: BW];

endmodule

// File: rtl/score_display_ctrl.sv
// Scoreboard controller: clamps and converts the live score, keeps the high score,
// and multiplexes both fields onto a common-anode display with blanking and blink.
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int SCORE_W     = 14,
  parameter int BCD_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_valid,
  input  logic                    gameover,
  output logic [2*BCD_DIGITS-1:0] anode,
  output logic [6:0]              cathode,
  output logic                    busy
);

  localparam int ND   = 2 * BCD_DIGITS;
  localparam int BW   = 4 * BCD_DIGITS;
  localparam int DW   = $clog2(ND);
  localparam int RW   = $clog2(REFRESH_DIV + 1);
  localparam int KW   = $clog2(BLINK_DIV + 1);
  localparam int SMAX = pow10(BCD_DIGITS) - 1;

  conv_state_e        state_r;
  logic [SCORE_W-1:0] src_r, pend_val_r, cur_bin_r, hi_bin_r;
  logic [BW-1:0]      cur_bcd_r, hi_bcd_r;
  logic               pend_r, busy_r, arm_r, go_d_r, blink_ph_r;
  logic [DW-1:0]      digit_r;
  logic [RW-1:0]      ref_cnt_r;
  logic [KW-1:0]      blink_cnt_r;
  logic [ND-1:0]      anode_r;
  logic [6:0]         cathode_r;

  logic [SCORE_W-1:0] score_clamp_s, eng_bin_s;
  logic               eng_start_s, eng_busy_s, eng_done_s;
  logic [BW-1:0]      eng_bcd_s, field_s;
  logic [DW-1:0]      pos_s;
  logic [3:0]         nib_s;
  logic               nz_above_s, blank_s;
  logic [6:0]         seg_s;
  logic [ND-1:0]      anode_s;

  assign score_clamp_s = ($unsigned(32'(score)) > $unsigned(32'(SMAX))) ? SCORE_W'(SMAX) : score;

  // Engine start request and operand, mirroring the FSM transitions into SHIFT
  always_comb begin
    eng_start_s = 1'b0;
    eng_bin_s   = score_clamp_s;
    case (state_r)
      ST_IDLE: begin
        if (score_valid) begin
          eng_start_s = 1'b1;
          eng_bin_s   = score_clamp_s;
        end else if (pend_r) begin
          eng_start_s = 1'b1;
          eng_bin_s   = pend_val_r;
        end else begin
          eng_start_s = 1'b0;
          eng_bin_s   = score_clamp_s;
        end
      end
      ST_DONE: begin
        if (pend_r) begin
          eng_start_s = 1'b1;
          eng_bin_s   = pend_val_r;
        end else begin
          eng_start_s = 1'b0;
          eng_bin_s   = score_clamp_s;
        end
      end
      default: begin
        eng_start_s = 1'b0;
        eng_bin_s   = score_clamp_s;
      end
    endcase
  end

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (eng_start_s),
    .bin   (eng_bin_s),
    .busy  (eng_busy_s),
    .done  (eng_done_s),
    .bcd   (eng_bcd_s)
  );

  // Conversion sequencing, latest-value-wins pending request and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      src_r      <= {SCORE_W{1'b0}};
      pend_val_r <= {SCORE_W{1'b0}};
      pend_r     <= 1'b0;
      cur_bcd_r  <= {BW{1'b0}};
      cur_bin_r  <= {SCORE_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (score_valid) begin
            src_r   <= score_clamp_s;
            pend_r  <= 1'b0;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else if (pend_r) begin
            src_r   <= pend_val_r;
            pend_r  <= 1'b0;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (score_valid) begin
            pend_r     <= 1'b1;
            pend_val_r <= score_clamp_s;
          end
          // An engine that stopped without finishing drops us back to IDLE
          if (eng_done_s) begin
            state_r <= ST_DONE;
          end else if (!eng_busy_s) begin
            state_r <= ST_IDLE;
          end
          busy_r <= eng_busy_s;
        end
        ST_DONE: begin
          cur_bcd_r <= eng_bcd_s;
          cur_bin_r <= src_r;
          pend_r    <= score_valid;
          if (score_valid) begin
            pend_val_r <= score_clamp_s;
          end
          if (pend_r) begin
            src_r   <= pend_val_r;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          pend_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // High-score capture, armed by a gameover rise and run once the converter is quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_d_r   <= 1'b0;
      arm_r    <= 1'b0;
      hi_bin_r <= {SCORE_W{1'b0}};
      hi_bcd_r <= {BW{1'b0}};
    end else begin
      go_d_r <= gameover;
      if (gameover && !go_d_r) begin
        arm_r <= 1'b1;
      end else if (arm_r && (state_r == ST_IDLE) && !pend_r) begin
        arm_r <= 1'b0;
        if (cur_bin_r > hi_bin_r) begin
          hi_bin_r <= cur_bin_r;
          hi_bcd_r <= cur_bcd_r;
        end
      end
    end
  end

  // Digit refresh and game-over blink timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_r   <= {RW{1'b0}};
      digit_r     <= {DW{1'b0}};
      blink_cnt_r <= {KW{1'b0}};
      blink_ph_r  <= 1'b0;
    end else begin
      if (ref_cnt_r == RW'(REFRESH_DIV - 1)) begin
        ref_cnt_r <= {RW{1'b0}};
        digit_r   <= (digit_r == DW'(ND - 1)) ? {DW{1'b0}} : digit_r + 1'b1;
      end else begin
        ref_cnt_r <= ref_cnt_r + 1'b1;
      end
      if (!gameover) begin
        blink_cnt_r <= {KW{1'b0}};
        blink_ph_r  <= 1'b0;
      end else if (blink_cnt_r == KW'(BLINK_DIV - 1)) begin
        blink_cnt_r <= {KW{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
    end
  end

  // Field select, leading-zero blanking and anode pattern for the current digit
  always_comb begin
    field_s    = cur_bcd_r;
    pos_s      = digit_r;
    nz_above_s = 1'b0;
    if (digit_r < DW'(BCD_DIGITS)) begin
      field_s = cur_bcd_r;
      pos_s   = digit_r;
    end else begin
      field_s = hi_bcd_r;
      pos_s   = digit_r - DW'(BCD_DIGITS);
    end
    nib_s = field_s[4*pos_s +: 4];
    for (int j = 0; j < BCD_DIGITS; j++) begin
      if ((DW'(j) > pos_s) && (field_s[4*j +: 4] != 4'd0)) begin
        nz_above_s = 1'b1;
      end else begin
        nz_above_s = nz_above_s;
      end
    end
    blank_s = (pos_s != {DW{1'b0}}) && !nz_above_s && (nib_s == 4'd0);
    if (blank_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_glyph(nib_s);
    end
    // Gameover is used directly so scanning resumes the cycle after it falls
    if (gameover && blink_ph_r) begin
      anode_s = {ND{1'b1}};
    end else begin
      anode_s = ~(ND'(1) << digit_r);
    end
  end

  // Registered display drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_r   <= {ND{1'b1}};
      cathode_r <= SEG_BLANK;
    end else begin
      anode_r   <= anode_s;
      cathode_r <= seg_s;
    end
  end

  assign anode   = anode_r;
  assign cathode = cathode_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: conversion table plus hand-written
// sequences for pending requests, high score, blink and mid-conversion reset.
module tb_score_display_ctrl;

  localparam int SW  = 14;
  localparam int BD  = 4;
  localparam int ND  = 2 * BD;
  localparam int RD  = 3;
  localparam int BLK = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] score = '0;
  logic          score_valid = 1'b0;
  logic          gameover = 1'b0;
  logic [ND-1:0] anode;
  logic [6:0]    cathode;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(
    .SCORE_W     (SW),
    .BCD_DIGITS  (BD),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BLK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .gameover    (gameover),
    .anode       (anode),
    .cathode     (cathode),
    .busy        (busy)
  );

  typedef struct {
    int score;
    int exp_cur;
  } vec_t;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected four cathode codes of one field holding decimal value v
  function automatic logic [27:0] field_exp(input int v);
    logic [27:0] r;
    int div;
    div = 1;
    for (int p = 0; p < BD; p++) begin
      if (p == 0 || v >= div) r[7*p +: 7] = glyph((v / div) % 10);
      else r[7*p +: 7] = 7'h7F;
      div = div * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Watch a couple of full refresh rounds and record what each digit shows
  task automatic scan(output logic [8*7-1:0] segs, output logic ok);
    logic [ND-1:0] seen;
    seen = '0;
    ok   = 1'b1;
    segs = '1;
    repeat (2 * ND * RD + 4) begin
      @(negedge clk);
      if (anode != {ND{1'b1}}) begin
        if ($countones(~anode) != 1) ok = 1'b0;
        for (int i = 0; i < ND; i++) begin
          if (!anode[i]) begin
            segs[7*i +: 7] = cathode;
            seen[i] = 1'b1;
          end
        end
      end
    end
    if (seen != {ND{1'b1}}) ok = 1'b0;
  endtask

  task automatic check_display(input string name, input int cur, input int hi);
    logic [8*7-1:0] segs;
    logic ok;
    scan(segs, ok);
    check({name, "_scan"}, 64'(ok), 64'd1);
    check({name, "_lo"}, 64'(segs[27:0]), 64'(field_exp(cur)));
    check({name, "_hi"}, 64'(segs[55:28]), 64'(field_exp(hi)));
  endtask

  // Pulse score_valid and count busy cycles until the conversion ends
  task automatic convert(input int v, output int busy_cycles);
    @(negedge clk);
    score = SW'(v);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic gameover_pulse();
    @(negedge clk);
    gameover = 1'b1;
    repeat (3) @(negedge clk);
    gameover = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int   bc;
    int   errs;

    vecs[0] = '{1234, 1234};
    vecs[1] = '{16383, 9999};
    vecs[2] = '{7, 7};
    vecs[3] = '{0, 0};
    vecs[4] = '{10000, 9999};
    vecs[5] = '{9999, 9999};
    vecs[6] = '{1000, 1000};
    vecs[7] = '{9050, 9050};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_anode", 64'(anode), 64'hFF);
    check("rst_cathode", 64'(cathode), 64'h7F);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    check_display("rst_disp", 0, 0);

    // Conversion table
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].score, bc);
      check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd15);
      check_display($sformatf("v%0d", i), vecs[i].exp_cur, 0);
    end

    // Back-to-back requests: 6 and 9 arrive while busy, only 9 is converted next
    @(negedge clk);
    score = SW'(5);
    score_valid = 1'b1;
    @(negedge clk);
    score = SW'(6);
    @(negedge clk);
    score = SW'(9);
    @(negedge clk);
    score_valid = 1'b0;
    bc = 2;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      bc++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 64'(bc), 64'd30);
    check_display("b2b", 9, 0);

    // High-score tracking
    convert(250, bc);
    gameover_pulse();
    check_display("hs_250", 250, 250);
    convert(100, bc);
    gameover_pulse();
    check_display("hs_100", 100, 250);
    convert(250, bc);
    gameover_pulse();
    check_display("hs_eq", 250, 250);
    convert(300, bc);
    gameover_pulse();
    check_display("hs_300", 300, 300);

    // Gameover rising together with score_valid waits for that conversion
    @(negedge clk);
    score = SW'(400);
    score_valid = 1'b1;
    gameover = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (20) @(negedge clk);
    gameover = 1'b0;
    check_display("hs_defer", 400, 400);

    // Blink: alternating 8-cycle phases, scanning returns right after the fall
    @(negedge clk);
    gameover = 1'b1;
    errs = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((anode == {ND{1'b1}}) != (((k / BLK) % 2) == 1)) errs++;
    end
    check("blink_pattern_errs", 64'(errs), 64'd0);
    gameover = 1'b0;
    @(negedge clk);
    check("blink_resume_lit", 64'($countones(~anode)), 64'd1);
    check_display("blink_after", 400, 400);

    // Reset in the middle of a conversion
    @(negedge clk);
    score = SW'(4321);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_anode", 64'(anode), 64'hFF);
    check("midrst_cathode", 64'(cathode), 64'h7F);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_display("midrst_disp", 0, 0);
    convert(42, bc);
    check("post_rst_busy_cycles", 64'(bc), 64'd15);
    check_display("post_rst", 42, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Parametrised seven-segment scoreboard controller, successor to the fixed 14-bit/8-digit scoreboard. It converts the live game score to BCD with a sequential double-dabble engine, tracks a high score across games, and time-multiplexes both onto a common-anode display with leading-zero blanking and a game-over blink mode. It sits between the game logic (score, gameover) and the board's anode/cathode pins.

## Interface
- SCORE_W, 14: width of binary score input.
- BCD_DIGITS, 4: decimal digits per field; display width is 2*BCD_DIGITS.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be at least 1.
- BLINK_DIV, 25000000: clk cycles per blink half-period in game-over mode; must be at least 1.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- score  in  SCORE_W  current binary score.
- score_valid  in  1  one-cycle strobe: sample score and start conversion.
- gameover  in  1  level; high while the game is over.
- anode  out  2*BCD_DIGITS  active-low digit enables, at most one low.
- cathode  out  7  active-low segments {g,f,e,d,c,b,a}.
- busy  out  1  conversion in progress.

## Operation
- Saturation: SMAX = 10^BCD_DIGITS-1. A sampled score greater than SMAX is clamped to SMAX before conversion.
- Converter FSM states:
  - IDLE: on score_valid, latch the clamped score into src and go to SHIFT.
  - SHIFT: SCORE_W iterations. Each iteration adds 3 to every BCD nibble that is 5 or more, then shifts left by one bit.
  - DONE: cur_bcd <= result, cur_bin <= src, then return to IDLE.
- Arrival during conversion: score_valid while busy sets a pending flag and overwrites pend_val, so only the latest value is kept. From DONE, a set pending flag goes straight to SHIFT with pend_val loaded. No request is lost, but intermediate values may be skipped.
- High score:
  - Capture is armed on the gameover rising edge.
  - It executes on the first cycle in which the armed flag is set and the converter is IDLE with no pending request.
  - On execution, if cur_bin > hi_bin then hi_bin <= cur_bin and hi_bcd <= cur_bcd. The armed flag then clears.
  - An equal score does not update the high score.
  - The high score survives everything except reset.
- Display:
  - Digit index d runs 0 to 2*BCD_DIGITS-1.
  - d < BCD_DIGITS shows nibble d of cur_bcd.
  - The remaining digits show nibble d-BCD_DIGITS of hi_bcd.
- Leading-zero blanking applies per field. A zero nibble above the field's highest nonzero nibble is driven dark (cathode 7'h7F with its anode still enabled). The least significant digit of each field is always shown, so a zero field displays "0".
- Blink: while gameover=1, blink_ph toggles every BLINK_DIV cycles. When blink_ph=1, anode is all ones. When gameover falls, blink_ph is forced to 0 and its counter cleared.
- Glyphs cover 0-9 only. Any other nibble value drives cathode 7'h7F.

## Timing
- Reset values:
  - anode all ones, cathode 7'h7F, busy 0.
  - cur_bcd, cur_bin, hi_bcd, hi_bin all 0.
  - d = 0, refresh counter 0, blink_ph 0, pending flag 0, armed flag 0.
- Conversion latency: score_valid at cycle t gives busy=1 from t+1. cur_bcd updates at t+SCORE_W+2 and busy=0 from t+SCORE_W+2.
- Display output: anode and cathode are registered and reflect cur_bcd one cycle after it updates, at the next digit they select. The display never shows a partial conversion.
- Refresh: d advances once every REFRESH_DIV cycles and wraps from 2*BCD_DIGITS-1 to 0. The first advance happens REFRESH_DIV cycles after reset release.
- Simultaneous events:
  - score_valid in the DONE cycle counts as pending.
  - A gameover rise on the same cycle as score_valid defers capture until that conversion completes.
- Reset mid-conversion aborts immediately to IDLE with all values at reset.

## Structure
- Package score_display_pkg holds:
  - the seven-segment glyph constants for 0-9 and blank;
  - the FSM state encoding (IDLE, SHIFT, DONE);
  - a constant function pow10(n) for SMAX.
- Sub-module bin2bcd_seq holds the iterative double-dabble engine, parametrised by SCORE_W and BCD_DIGITS. It has a start/busy/done handshake and is owned by the top-level FSM.
- The top level contains the refresh counter, blink counter, high-score logic, blanking, and output registers.

## Test plan
- Reset, then score=1234 with a score_valid pulse: busy=1 for 15 cycles. Afterwards the low field scans 4,3,2,1 and the high field shows blank,blank,blank,0.
- score=16383: displays 9999 (saturation). score=7: displays blank,blank,blank,7.
- Back-to-back score_valid pulses with 5, 6, then 9 while busy: exactly one further conversion runs, and the final display is 9.
- Sequence: cur=250, gameover rises, then cur=100 and gameover rises again. Result: hi=250 after the first rise and still 250 after the second. A later cur=250 followed by a gameover rise leaves hi unchanged.
- gameover held high with BLINK_DIV=8: anode alternates between all ones and scanning every 8 cycles. Dropping gameover resumes scanning the next cycle.
- Assert rst_n low mid-SHIFT: all outputs return to reset values asynchronously. The next conversion after release is correct.
